multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: begin execution from address 8'h00.
REQ-004 The block SHALL have port ReadInstr, input, 16 bits: instruction word from instruction memory at InstrAddr, combinational.
REQ-005 The block SHALL have port ALUFlags, input, 4 bits: {N,Z,C,V} from the ALU.
REQ-006 The block SHALL have port InstrAddr, output, 8 bits: program counter (PC).
REQ-007 The block SHALL have ports WE, output, 1 bit, and ALUorM, output, 1 bit: register write enable, and result select (0 = ALU, 1 = memory).
REQ-008 The block SHALL have ports ALUCntr, output, 3 bits, and ALUSrc2, output, 1 bit: ALU operation, and operand-2 select.
REQ-009 The block SHALL have ports RDst3, output, 2 bits; RSrc1, output, 2 bits; Src2, output, 8 bits: register and operand fields.
REQ-010 The block SHALL have ports state, output, 3 bits, and halted, output, 1 bit: current FSM state, and high while in HALT.

Function
REQ-011 The block SHALL decode IR as: [15:13] opcode, [12:11] RDst3/cond, [10:9] RSrc1, [8] ALUSrc2, [7:0] Src2/target.
REQ-012 The block SHALL treat opcodes 000–101 as ALU ops with ALUCntr = opcode; opcode 110 = branch; opcode 111 = halt.
REQ-013 The block SHALL implement states IDLE=000, FETCH=001, EXEC=010, WB=011, HALT=100.
REQ-014 In IDLE, start=1 SHALL load PC=8'h00 and go to FETCH next cycle; start SHALL be ignored in FETCH, EXEC and WB.
REQ-015 In FETCH, the block SHALL latch ReadInstr into IR and go to EXEC.
REQ-016 In EXEC with an ALU op, the block SHALL drive ALUCntr, ALUSrc2, RDst3, RSrc1 and Src2 from IR, latch ALUFlags into the flag register, and go to WB.
REQ-017 In WB, the block SHALL hold the EXEC field values, assert WE=1 and ALUorM=0 for exactly one cycle, set PC=PC+1, and go to FETCH.
REQ-018 In EXEC with a branch, cond SHALL be 00 always, 01 latched Z, 10 latched N, 11 latched C; taken sets PC=IR[7:0], not-taken sets PC=PC+1; next state FETCH; WE=0; flags unchanged.
REQ-019 In EXEC with a halt, the block SHALL go to HALT with PC unchanged; HALT SHALL hold halted=1 and WE=0.
REQ-020 In HALT, start=1 SHALL load PC=8'h00 and go to FETCH.
REQ-021 Latency: ALU op 3 cycles, branch 2 cycles, halt 2 cycles to HALT.
REQ-022 PC increment SHALL wrap 8'hFF to 8'h00.
REQ-023 Outside EXEC/WB, ALUCntr, ALUSrc2, RDst3, RSrc1, Src2, WE and ALUorM SHALL be 0.
REQ-024 A branch immediately after an ALU op SHALL use the flags latched in that op's EXEC.

Reset
REQ-025 On reset assertion, asynchronously and at any state including mid-instruction, the block SHALL set: state=IDLE, PC=8'h00, IR=16'h0000, flags=4'h0, every output 0.
REQ-026 The block SHALL leave IDLE no earlier than the first rising edge after reset deassertion with start=1.

Configuration
REQ-027 When SEQ_STEP_EN is defined, the block SHALL have an extra input port step (1 bit), and a transition into FETCH from WB or branch-EXEC SHALL wait in a PAUSE state (3'b101) until step=1.
REQ-028 When SEQ_STEP_EN is defined, the IDLE/HALT start transition SHALL NOT require step.
REQ-029 When SEQ_STEP_EN is undefined, the step port and the PAUSE state SHALL be absent and execution SHALL free-run.

Verification
REQ-030 Scenario: reset, start pulse, mem[0]=16'h2305 (op 001, RDst3=0, RSrc1=1, ALUSrc2=1, Src2=05) -> states 001,010,011; WE=1 only in the 011 cycle; ALUCntr=001 and Src2=8'h05 in EXEC/WB; PC=8'h01 after WB.
REQ-031 Scenario: ALU op with ALUFlags=4'b0100, then mem[1]=16'hC820 (branch on Z, target 8'h20) -> InstrAddr=8'h20 on the next FETCH; with ALUFlags=0 instead -> InstrAddr=8'h02.
REQ-032 Scenario: mem[0]=16'hE000 -> HALT reached after 2 cycles, halted=1, PC=8'h00 held; start pulse -> FETCH at 8'h00.
REQ-033 Scenario: mem[8'hFF] holds an ALU op reached via branch -> PC wraps to 8'h00 after WB.
REQ-034 Scenario: reset asserted mid-WB -> WE drops and state=000 in the same cycle without a clock edge; start ignored while in EXEC.
REQ-035 Scenario (SEQ_STEP_EN): after WB, state=101 is held for 5 cycles with step=0; step=1 -> FETCH next cycle.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: IDLE/FETCH/EXEC/WB/HALT control FSM with PC, IR and flag register.
// Optional single-step PAUSE state is enabled by defining SEQ_STEP_EN.
module multicycle_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef SEQ_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] ReadInstr,
  input  logic [3:0]  ALUFlags,
  output logic [7:0]  InstrAddr,
  output logic        WE,
  output logic        ALUorM,
  output logic [2:0]  ALUCntr,
  output logic        ALUSrc2,
  output logic [1:0]  RDst3,
  output logic [1:0]  RSrc1,
  output logic [7:0]  Src2,
  output logic [2:0]  state,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_FETCH = 3'b001,
    S_EXEC  = 3'b010,
    S_WB    = 3'b011,
    S_HALT  = 3'b100
`ifdef SEQ_STEP_EN
    , S_PAUSE = 3'b101
`endif
  } state_t;

`ifdef SEQ_STEP_EN
  localparam state_t RESUME = S_PAUSE;
`else
  localparam state_t RESUME = S_FETCH;
`endif

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;

  logic [2:0]  opcode;
  logic [1:0]  cond;
  logic        is_alu;
  logic        is_branch;
  logic        taken;
  logic        drive_fields;
  logic        flags_unused;

  assign opcode    = ir_q[15:13];
  assign cond      = ir_q[12:11];
  assign is_alu    = !(opcode[2] && opcode[1]);
  assign is_branch = (opcode == 3'b110);

  // Flags are {N,Z,C,V}; V is latched but no branch condition tests it.
  assign flags_unused = flags_q[0];

  always_comb begin
    unique case (cond)
      2'b00:   taken = 1'b1;
      2'b01:   taken = flags_q[2];
      2'b10:   taken = flags_q[3];
      default: taken = flags_q[1];
    endcase
  end

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = 8'h00;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = ReadInstr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_alu) begin
          flags_d = ALUFlags;
          state_d = S_WB;
        end else if (is_branch) begin
          pc_d    = taken ? ir_q[7:0] : pc_q + 8'h01;
          state_d = RESUME;
        end else begin
          state_d = S_HALT;
        end
      end
      S_WB: begin
        pc_d    = pc_q + 8'h01;
        state_d = RESUME;
      end
`ifdef SEQ_STEP_EN
      S_PAUSE: begin
        if (step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= 8'h00;
      ir_q    <= 16'h0000;
      flags_q <= 4'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Field outputs are live only while an ALU op is executing or writing back.
  assign drive_fields = ((state_q == S_EXEC) && is_alu) || (state_q == S_WB);

  assign ALUCntr   = drive_fields ? opcode     : 3'b000;
  assign RDst3     = drive_fields ? ir_q[12:11] : 2'b00;
  assign RSrc1     = drive_fields ? ir_q[10:9]  : 2'b00;
  assign ALUSrc2   = drive_fields ? ir_q[8]     : 1'b0;
  assign Src2      = drive_fields ? ir_q[7:0]   : 8'h00;
  assign WE        = (state_q == S_WB);
  assign ALUorM    = 1'b0;
  assign InstrAddr = pc_q;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; instruction memory is a bench-side array.
module tb_multicycle_sequencer;

  localparam logic [2:0] IDLE  = 3'b000;
  localparam logic [2:0] FETCH = 3'b001;
  localparam logic [2:0] EXEC  = 3'b010;
  localparam logic [2:0] WB    = 3'b011;
  localparam logic [2:0] HALT  = 3'b100;
  localparam logic [2:0] PAUSE = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        step;
  logic [15:0] ReadInstr;
  logic [3:0]  ALUFlags;
  logic [7:0]  InstrAddr;
  logic        WE;
  logic        ALUorM;
  logic [2:0]  ALUCntr;
  logic        ALUSrc2;
  logic [1:0]  RDst3;
  logic [1:0]  RSrc1;
  logic [7:0]  Src2;
  logic [2:0]  state;
  logic        halted;

  logic [15:0] mem [256];
  int compared   = 0;
  int mismatched = 0;

  assign ReadInstr = mem[InstrAddr];

  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef SEQ_STEP_EN
    .step      (step),
`endif
    .ReadInstr (ReadInstr),
    .ALUFlags  (ALUFlags),
    .InstrAddr (InstrAddr),
    .WE        (WE),
    .ALUorM    (ALUorM),
    .ALUCntr   (ALUCntr),
    .ALUSrc2   (ALUSrc2),
    .RDst3     (RDst3),
    .RSrc1     (RSrc1),
    .Src2      (Src2),
    .state     (state),
    .halted    (halted)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  // One instruction-level step; in the single-step build a PAUSE is released transparently.
  task automatic tick();
    @(negedge clk);
`ifdef SEQ_STEP_EN
    if (state == PAUSE) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end
`endif
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    step     = 1'b0;
    ALUFlags = 4'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]     = 16'h2305;
    mem[1]     = 16'hC820;
    mem[8'h20] = 16'hE000;
    cycle();
    cycle();
    check("rst_state",  16'(state), 16'(IDLE));
    check("rst_pc",     16'(InstrAddr), 16'h00);
    check("rst_we",     16'(WE), 16'h0);
    check("rst_halted", 16'(halted), 16'h0);
    reset = 1'b0;
    cycle();
    check("idle_no_start", 16'(state), 16'(IDLE));

    // ALU op 16'h2305 with Z set, then branch-on-Z to 8'h20 which halts
    start    = 1'b1;
    ALUFlags = 4'b0100;
    tick();
    start = 1'b0;
    check("alu_fetch_state", 16'(state), 16'(FETCH));
    check("alu_fetch_pc",    16'(InstrAddr), 16'h00);
    check("alu_fetch_we",    16'(WE), 16'h0);
    check("alu_fetch_cntr",  16'(ALUCntr), 16'h0);
    check("alu_fetch_src2",  16'(Src2), 16'h00);
    start = 1'b1;
    tick();
    check("alu_exec_state",  16'(state), 16'(EXEC));
    check("alu_exec_cntr",   16'(ALUCntr), 16'h1);
    check("alu_exec_src2",   16'(Src2), 16'h05);
    check("alu_exec_rsrc1",  16'(RSrc1), 16'h1);
    check("alu_exec_srcsel", 16'(ALUSrc2), 16'h1);
    check("alu_exec_rdst",   16'(RDst3), 16'h0);
    check("alu_exec_we",     16'(WE), 16'h0);
    tick();
    check("alu_wb_state", 16'(state), 16'(WB));
    check("alu_wb_we",    16'(WE), 16'h1);
    check("alu_wb_aluorm", 16'(ALUorM), 16'h0);
    check("alu_wb_cntr",  16'(ALUCntr), 16'h1);
    check("alu_wb_src2",  16'(Src2), 16'h05);
    check("alu_wb_pc",    16'(InstrAddr), 16'h00);
    start    = 1'b0;
    ALUFlags = 4'h0;
    tick();
    check("br_fetch_state", 16'(state), 16'(FETCH));
    check("br_fetch_pc",    16'(InstrAddr), 16'h01);
    check("br_fetch_we",    16'(WE), 16'h0);
    check("br_fetch_cntr",  16'(ALUCntr), 16'h0);
    tick();
    check("br_exec_state", 16'(state), 16'(EXEC));
    check("br_exec_we",    16'(WE), 16'h0);
    tick();
    check("br_taken_pc",    16'(InstrAddr), 16'h20);
    check("br_taken_state", 16'(state), 16'(FETCH));
    tick();
    tick();
    check("halt_state",  16'(state), 16'(HALT));
    check("halt_flag",   16'(halted), 16'h1);
    check("halt_pc",     16'(InstrAddr), 16'h20);
    check("halt_we",     16'(WE), 16'h0);
    tick();
    check("halt_hold", 16'(state), 16'(HALT));

    // Restart from HALT, same program but Z clear: branch falls through
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_state",  16'(state), 16'(FETCH));
    check("restart_pc",     16'(InstrAddr), 16'h00);
    check("restart_halted", 16'(halted), 16'h0);
    tick();
    tick();
    tick();
    tick();
    tick();
    check("br_not_taken_pc",    16'(InstrAddr), 16'h02);
    check("br_not_taken_state", 16'(state), 16'(FETCH));

    // Halt as the first instruction
    pulse_reset();
    mem[0] = 16'hE000;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("h0_fetch", 16'(state), 16'(FETCH));
    tick();
    tick();
    check("h0_state",  16'(state), 16'(HALT));
    check("h0_halted", 16'(halted), 16'h1);
    check("h0_pc",     16'(InstrAddr), 16'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("h0_restart_state", 16'(state), 16'(FETCH));
    check("h0_restart_pc",    16'(InstrAddr), 16'h00);

    // Branch-always to 8'hFF, ALU op there, PC wraps to 8'h00
    pulse_reset();
    mem[0]     = 16'hC0FF;
    mem[8'hFF] = 16'h0000;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("wrap_at_ff", 16'(InstrAddr), 16'hFF);
    tick();
    tick();
    check("wrap_wb_we", 16'(WE), 16'h1);
    tick();
    check("wrap_pc",    16'(InstrAddr), 16'h00);
    check("wrap_state", 16'(state), 16'(FETCH));

    // Asynchronous reset in the middle of WB, then confirm flags were cleared
    pulse_reset();
    mem[0]   = 16'h2305;
    ALUFlags = 4'b0100;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("midwb_we_before", 16'(WE), 16'h1);
    #1 reset = 1'b1;
    #1;
    check("midwb_we_async",    16'(WE), 16'h0);
    check("midwb_state_async", 16'(state), 16'(IDLE));
    check("midwb_cntr_async",  16'(ALUCntr), 16'h0);
    cycle();
    reset    = 1'b0;
    mem[0]   = 16'hC820;
    ALUFlags = 4'h0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("flags_cleared_pc", 16'(InstrAddr), 16'h01);

`ifdef SEQ_STEP_EN
    pulse_reset();
    mem[0] = 16'h2305;
    start  = 1'b1;
    cycle();
    start = 1'b0;
    check("step_start_no_step", 16'(state), 16'(FETCH));
    cycle();
    cycle();
    check("step_wb", 16'(state), 16'(WB));
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("step_pause_hold", 16'(state), 16'(PAUSE));
    end
    step = 1'b1;
    cycle();
    step = 1'b0;
    check("step_release_state", 16'(state), 16'(FETCH));
    check("step_release_pc",    16'(InstrAddr), 16'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
